// File: rtl/latch_interval_sequencer_pkg.sv
// rtl/latch_interval_sequencer_pkg.sv - shared state encoding and timestamp width
package latch_interval_sequencer_pkg;

    localparam int LIS_WIDTH = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM1,
        ST_ARM2,
        ST_CALC,
        ST_PRESENT,
        ST_RELEASE
    } lis_state_t;

endpackage

// File: rtl/latch_interval_sequencer_sync2.sv
// rtl/latch_interval_sequencer_sync2.sv - generic two-flop synchronizer
module latch_interval_sequencer_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/latch_interval_sequencer.sv
// rtl/latch_interval_sequencer.sv - captures two latched timestamps and presents their modular interval
module latch_interval_sequencer
    import latch_interval_sequencer_pkg::*;
#(
    parameter int                    pWIDTH     = LIS_WIDTH,
    parameter int                    pTIMEOUT_W = 24,
    parameter logic [pTIMEOUT_W-1:0] pTIMEOUT   = 24'hFFFFFF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iRdy1,
    input  logic [31:0]       i1COUNTER,
    input  logic [7:0]        i1COUNTERHi,
    input  logic              iRdy2,
    input  logic [31:0]       i2COUNTER,
    input  logic [7:0]        i2COUNTERHi,
    input  logic              iAck,
    input  logic              iClrErr,
    output logic              oResetLatch1,
    output logic              oResetLatch2,
    output logic [pWIDTH-1:0] oDelta,
    output logic              oOrder,
    output logic              oValid,
    output logic              oBusy,
    output logic              oTimeout
);

    localparam logic [pTIMEOUT_W-1:0] TO_LAST = pTIMEOUT - 1'b1;

    logic              rdy1_s;
    logic              rdy2_s;
    logic [pWIDTH-1:0] ts1;
    logic [pWIDTH-1:0] ts2;

    lis_state_t              state_q;
    logic [pWIDTH-1:0]       t1_q;
    logic [pWIDTH-1:0]       t2_q;
    logic [pWIDTH-1:0]       delta_q;
    logic [pWIDTH-1:0]       delta_d;
    logic [pTIMEOUT_W-1:0]   cnt_q;
    logic                    order_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    timeout_q;
    logic                    rst_latch_q;

    latch_interval_sequencer_sync2 u_sync_rdy1 (
        .clk_i (iCLK),
        .rst_i (iRST),
        .d_i   (iRdy1),
        .q_o   (rdy1_s)
    );

    latch_interval_sequencer_sync2 u_sync_rdy2 (
        .clk_i (iCLK),
        .rst_i (iRST),
        .d_i   (iRdy2),
        .q_o   (rdy2_s)
    );

    // The counter holds its buses static once rdy is up, so no resync is needed.
    assign ts1 = {i1COUNTERHi, i1COUNTER};
    assign ts2 = {i2COUNTERHi, i2COUNTER};

    assign delta_d = order_q ? (t1_q - t2_q) : (t2_q - t1_q);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            t1_q        <= '0;
            t2_q        <= '0;
            delta_q     <= '0;
            cnt_q       <= '0;
            order_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            rst_latch_q <= 1'b0;
        end else begin
            // A timeout set below overrides this clear in the same cycle.
            if (iClrErr) begin
                timeout_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rdy1_s && rdy2_s) begin
                        t1_q    <= ts1;
                        t2_q    <= ts2;
                        order_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end else if (rdy1_s) begin
                        t1_q    <= ts1;
                        order_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ARM2;
                    end else if (rdy2_s) begin
                        t2_q    <= ts2;
                        order_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_ARM1;
                    end
                end
                ST_ARM1, ST_ARM2: begin
                    if (state_q == ST_ARM2 && rdy2_s) begin
                        t2_q    <= ts2;
                        state_q <= ST_CALC;
                    end else if (state_q == ST_ARM1 && rdy1_s) begin
                        t1_q    <= ts1;
                        state_q <= ST_CALC;
                    end else if (cnt_q == TO_LAST) begin
                        timeout_q   <= 1'b1;
                        rst_latch_q <= 1'b1;
                        state_q     <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CALC: begin
                    delta_q <= delta_d;
                    valid_q <= 1'b1;
                    state_q <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (iAck) begin
                        valid_q     <= 1'b0;
                        rst_latch_q <= 1'b1;
                        state_q     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!rdy1_s && !rdy2_s) begin
                        rst_latch_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign oResetLatch1 = rst_latch_q;
    assign oResetLatch2 = rst_latch_q;
    assign oDelta       = delta_q;
    assign oOrder       = order_q;
    assign oValid       = valid_q;
    assign oBusy        = busy_q;
    assign oTimeout     = timeout_q;

endmodule

// File: tb/tb_latch_interval_sequencer.sv
// tb/tb_latch_interval_sequencer.sv - scoreboard bench for latch_interval_sequencer
module tb_latch_interval_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rdy1, rdy2, ack, clr;
    logic [39:0] ts1, ts2;
    logic        latch1, latch2, order, valid, busy, timeout;
    logic [39:0] delta;

    logic        to_rdy1, to_clr;
    logic        to_latch1, to_latch2, to_order, to_valid, to_busy, to_timeout;
    logic [39:0] to_delta;

    latch_interval_sequencer dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iRdy1        (rdy1),
        .i1COUNTER    (ts1[31:0]),
        .i1COUNTERHi  (ts1[39:32]),
        .iRdy2        (rdy2),
        .i2COUNTER    (ts2[31:0]),
        .i2COUNTERHi  (ts2[39:32]),
        .iAck         (ack),
        .iClrErr      (clr),
        .oResetLatch1 (latch1),
        .oResetLatch2 (latch2),
        .oDelta       (delta),
        .oOrder       (order),
        .oValid       (valid),
        .oBusy        (busy),
        .oTimeout     (timeout)
    );

    latch_interval_sequencer #(.pTIMEOUT(24'd16)) dut_to (
        .iCLK         (clk),
        .iRST         (rst),
        .iRdy1        (to_rdy1),
        .i1COUNTER    (ts1[31:0]),
        .i1COUNTERHi  (ts1[39:32]),
        .iRdy2        (1'b0),
        .i2COUNTER    (ts2[31:0]),
        .i2COUNTERHi  (ts2[39:32]),
        .iAck         (ack),
        .iClrErr      (to_clr),
        .oResetLatch1 (to_latch1),
        .oResetLatch2 (to_latch2),
        .oDelta       (to_delta),
        .oOrder       (to_order),
        .oValid       (to_valid),
        .oBusy        (to_busy),
        .oTimeout     (to_timeout)
    );

    typedef struct packed {
        logic [39:0] delta;
        logic        order;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;
    logic to_valid_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each new result, then checks it stays stable.
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                held = exp_q.pop_front();
                check("delta", {24'd0, delta}, {24'd0, held.delta});
                check("order", {63'd0, order}, {63'd0, held.order});
            end
        end else if (valid) begin
            check("delta_hold", {24'd0, delta}, {24'd0, held.delta});
            check("order_hold", {63'd0, order}, {63'd0, held.order});
        end
        prev_valid = valid;
        if (to_valid) to_valid_seen = 1'b1;
    end

    task automatic run_txn(input logic [39:0] t1, input logic [39:0] t2, input int gap,
                           input bit ch2first, input int ack_dly, input int rel1, input int rel2);
        exp_t e;
        int   cyc;
        int   last;
        e.order = ch2first && (gap > 0);
        e.delta = e.order ? (t1 - t2) : (t2 - t1);
        exp_q.push_back(e);
        @(negedge clk);
        ts1 = t1;
        ts2 = t2;
        if (gap == 0) begin
            rdy1 = 1'b1;
            rdy2 = 1'b1;
        end else begin
            if (ch2first) rdy2 = 1'b1; else rdy1 = 1'b1;
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                ack = (gap > 3 && i == 1);
            end
            ack = 1'b0;
            if (ch2first) rdy1 = 1'b1; else rdy2 = 1'b1;
        end
        cyc = 0;
        while (!valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 4);
        repeat (ack_dly) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("valid_after_ack", {63'd0, valid}, 64'd0);
        check("latch1_on_release", {63'd0, latch1}, 64'd1);
        check("latch2_on_release", {63'd0, latch2}, 64'd1);
        last = (rel1 > rel2) ? rel1 : rel2;
        for (int i = 0; i <= last; i++) begin
            if (i == rel1) rdy1 = 1'b0;
            if (i == rel2) rdy2 = 1'b0;
            @(negedge clk);
            check("latch_held", {62'd0, latch1, latch2}, 64'd3);
        end
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_after_release", {62'd0, busy, latch1}, 64'd0);
    endtask

    initial begin
        int cyc;
        logic [39:0] r1, r2;
        rst = 1'b1; rdy1 = 1'b0; rdy2 = 1'b0; ack = 1'b0; clr = 1'b0;
        to_rdy1 = 1'b0; to_clr = 1'b0; ts1 = '0; ts2 = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {57'd0, valid, busy, timeout, latch1, latch2, order, |delta}, 64'd0);
        check("rst_outputs_to", {57'd0, to_valid, to_busy, to_timeout, to_latch1, to_latch2,
                                 to_order, |to_delta}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(40'h00_0000_0100, 40'h00_0000_0350, 20, 1'b0, 3, 2, 5);
        run_txn(40'h00_0000_1010, 40'h00_0000_0010, 5, 1'b1, 0, 4, 1);
        run_txn(40'hFF_FFFF_FFF0, 40'h00_0000_0010, 7, 1'b0, 1, 0, 0);
        run_txn(40'h00_0000_1234, 40'h00_0000_1234, 0, 1'b0, 2, 1, 3);
        for (int k = 0; k < 20; k++) begin
            r1 = {$urandom_range(0, 255), $urandom};
            r2 = {$urandom_range(0, 255), $urandom};
            run_txn(r1, r2, $urandom_range(0, 12), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Second channel never arrives on the short-timeout instance.
        @(negedge clk);
        to_rdy1 = 1'b1;
        cyc = 0;
        while (!to_busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("to_busy", {63'd0, to_busy}, 64'd1);
        cyc = 0;
        while (!to_timeout && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, 16);
        check("to_latch_on_timeout", {62'd0, to_latch1, to_latch2}, 64'd3);
        repeat (3) @(negedge clk);
        check("to_latch_held", {63'd0, to_latch1}, 64'd1);
        to_rdy1 = 1'b0;
        cyc = 0;
        while (to_busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("to_idle", {62'd0, to_busy, to_latch1}, 64'd0);
        check("timeout_sticky", {63'd0, to_timeout}, 64'd1);
        to_clr = 1'b1;
        @(negedge clk);
        to_clr = 1'b0;
        check("timeout_cleared", {63'd0, to_timeout}, 64'd0);
        check("to_never_valid", {63'd0, to_valid_seen}, 64'd0);

        // Reset while a result is being presented.
        exp_q.push_back('{delta: 40'h5, order: 1'b0});
        ts1 = 40'h10;
        ts2 = 40'h15;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        cyc = 0;
        while (!valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_test_valid", {63'd0, valid}, 64'd1);
        rst = 1'b1;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        @(negedge clk);
        check("rst_in_present", {57'd0, valid, busy, timeout, latch1, latch2, order, |delta}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_latch_after_rst", {62'd0, latch1, busy}, 64'd0);
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
